sd_cmd_tx: RTL

- Serialises one SD-bus command frame onto the CMD line: start bit, transmission bit, 6-bit index, 32-bit argument, CRC7, end bit (48 bits total).
- Sits directly upstream of the CRC7 generator. It feeds that generator the first 40 frame bits, then shifts the resulting CRC out on the line.
- Bit timing is paced by a one-cycle SD-clock strobe from the card clock generator, so the block runs entirely in the system clock domain.

---
 rtl/sd_pkg.sv | 22 ++
 rtl/sd_cmd_tx_if.sv | 21 ++
 rtl/crc7.sv | 20 ++
 rtl/sd_cmd_tx.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD command-path types and frame constants
package sd_pkg;

  localparam int CMD_FRAME_BITS   = 48;
  localparam int CMD_CRC_BITS     = 7;
  localparam int CMD_PAYLOAD_BITS = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC,
    ST_STOP,
    ST_TAIL,
    ST_GAP
  } sd_state_e;

  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] arg;
  } sd_cmd_t;

endpackage

// File: rtl/sd_cmd_tx_if.sv
// rtl/sd_cmd_tx_if.sv - command request and CMD-line signals of sd_cmd_tx
interface sd_cmd_tx_if;
  logic        strobe;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        ready;
  logic        cmd_out;
  logic        cmd_oe;
  logic        done;

  modport master (
    output strobe, start, cmd_index, cmd_arg,
    input  ready, cmd_out, cmd_oe, done
  );

  modport slave (
    input  strobe, start, cmd_index, cmd_arg,
    output ready, cmd_out, cmd_oe, done
  );
endinterface

// File: rtl/crc7.sv
// rtl/crc7.sv - serial CRC7 (x^7 + x^3 + 1), MSB-first, asynchronous clear
module crc7 (
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  input  logic       in,
  output logic [6:0] crc
);
  logic fb;

  assign fb = crc[6] ^ in;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[5:0], fb} ^ {3'b000, fb, 3'b000};
    end
  end
endmodule

// File: rtl/sd_cmd_tx.sv
// rtl/sd_cmd_tx.sv - SD CMD-line frame serialiser; SD_CMD_TX_GAP_EN adds the post-frame idle gap
module sd_cmd_tx
  import sd_pkg::*;
#(
  parameter int GAP_BITS = 8
) (
  input  logic       clk,
  input  logic       clear,
  sd_cmd_tx_if.slave bus
);

  sd_state_e                   state, state_nxt;
  logic [CMD_PAYLOAD_BITS-1:0] shreg, shreg_nxt;
  logic [5:0]                  bit_cnt, bit_cnt_nxt;
  logic [CMD_CRC_BITS-1:0]     crc, crc_bits;
  logic ready_q, ready_nxt, cmd_out_q, cmd_out_nxt, cmd_oe_q, cmd_oe_nxt, done_q, done_nxt;
  logic crc_init, crc_init_nxt, crc_clear, crc_en, accept, gap_last;
  sd_cmd_t cmd;

  assign accept    = bus.start && ready_q;
  assign cmd.index = bus.cmd_index;
  assign cmd.arg   = bus.cmd_arg;
  assign crc_clear = clear | crc_init;
  assign crc_en    = bus.strobe && (state == ST_DATA);

  // A strobe during the crc_init cycle is lost to the CRC, which is harmless: it carries the
  // start bit (0), and a zero bit into a zero CRC leaves it zero.
  crc7 u_crc7 (
    .clk    (clk),
    .clear  (crc_clear),
    .enable (crc_en),
    .in     (shreg[CMD_PAYLOAD_BITS-1]),
    .crc    (crc)
  );

`ifdef SD_CMD_TX_GAP_EN
  localparam int GW = $clog2(GAP_BITS + 1);
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      gap_cnt <= '0;
    end else if (state != ST_GAP) begin
      gap_cnt <= '0;
    end else if (bus.strobe) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  assign gap_last = (gap_cnt == GW'(GAP_BITS - 1));
`else
  // Keeps the parameter referenced; ST_GAP is unreachable in this build.
  assign gap_last = (GAP_BITS >= 0);
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      ready_q   <= 1'b1;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      crc_init  <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      ready_q   <= ready_nxt;
      cmd_out_q <= cmd_out_nxt;
      cmd_oe_q  <= cmd_oe_nxt;
      done_q    <= done_nxt;
      crc_init  <= crc_init_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_DATA;
      ST_DATA: if (bus.strobe && bit_cnt == 6'(CMD_PAYLOAD_BITS - 1)) state_nxt = ST_CRC;
      ST_CRC:  if (bus.strobe && bit_cnt == 6'(CMD_CRC_BITS - 1)) state_nxt = ST_STOP;
      ST_STOP: if (bus.strobe) state_nxt = ST_TAIL;
`ifdef SD_CMD_TX_GAP_EN
      ST_TAIL: if (bus.strobe) state_nxt = ST_GAP;
`else
      ST_TAIL: if (bus.strobe) state_nxt = ST_IDLE;
`endif
      ST_GAP:  if (bus.strobe && gap_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    cmd_out_nxt  = cmd_out_q;
    cmd_oe_nxt   = cmd_oe_q;
    done_nxt     = 1'b0;
    crc_init_nxt = 1'b0;
    ready_nxt    = (state == ST_IDLE) && !accept;
    // First CRC strobe takes the settled CRC; later ones shift it out of the register.
    crc_bits     = (bit_cnt == 6'd0) ? crc : shreg[CMD_PAYLOAD_BITS-1 -: CMD_CRC_BITS];
    case (state)
      ST_IDLE: if (accept) begin
        shreg_nxt    = {2'b01, cmd};
        bit_cnt_nxt  = '0;
        crc_init_nxt = 1'b1;
      end
      ST_DATA: if (bus.strobe) begin
        cmd_out_nxt = shreg[CMD_PAYLOAD_BITS-1];
        cmd_oe_nxt  = 1'b1;
        shreg_nxt   = {shreg[CMD_PAYLOAD_BITS-2:0], 1'b0};
        bit_cnt_nxt = (bit_cnt == 6'(CMD_PAYLOAD_BITS - 1)) ? 6'd0 : bit_cnt + 6'd1;
      end
      ST_CRC: if (bus.strobe) begin
        cmd_out_nxt = crc_bits[CMD_CRC_BITS-1];
        cmd_oe_nxt  = 1'b1;
        shreg_nxt   = {crc_bits[CMD_CRC_BITS-2:0], {(CMD_PAYLOAD_BITS-CMD_CRC_BITS+1){1'b0}}};
        bit_cnt_nxt = (bit_cnt == 6'(CMD_CRC_BITS - 1)) ? 6'd0 : bit_cnt + 6'd1;
      end
      ST_STOP: if (bus.strobe) begin
        cmd_out_nxt = 1'b1;
        cmd_oe_nxt  = 1'b1;
      end
      ST_TAIL: if (bus.strobe) begin
        cmd_out_nxt = 1'b1;
        cmd_oe_nxt  = 1'b0;
        done_nxt    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ready   = ready_q;
  assign bus.cmd_out = cmd_out_q;
  assign bus.cmd_oe  = cmd_oe_q;
  assign bus.done    = done_q;

endmodule
